// File: rtl/misc_demux_rx.sv
// -----------------------------------------------------------------------------
// misc_demux_rx
//
// Purpose:
//   Recovers two single-bit sources (A and B) from a time-multiplexed beat
//   stream. Each beat carries one data bit Y and a tag S0 that says which
//   source it belongs to: S0=0 is the A-phase and S0=1 is the B-phase. A
//   complete, in-order pair updates the A/B outputs and pulses PAIR_VLD.
//   Out-of-order beats and abandoned partial pairs pulse ERR.
//
//   Every output is a register, so a beat sampled on one rising edge has
//   its effect visible for the whole of the following cycle.
//
// Parameters:
//   TIMEOUT   idle (VLD=0) cycles tolerated in WAIT_B before the partial
//             pair is dropped. Legal range 2..255.
//
// Configuration macro:
//   MISC_DEMUX_CNT_EN  when defined, adds the PAIR_CNT output, an 8-bit
//                      wrapping count of completed pairs.
//
// Ports:
//   clk       in   1  clock; all state changes on the rising edge
//   rst       in   1  synchronous, active-high reset
//   VLD       in   1  a beat (Y/S0) is present this cycle
//   Y         in   1  data bit of the beat
//   S0        in   1  phase tag of the beat (0 = A, 1 = B)
//   A         out  1  recovered A bit, held until the next complete pair
//   B         out  1  recovered B bit, held until the next complete pair
//   PAIR_VLD  out  1  one-cycle pulse: A/B were just loaded with a new pair
//   ERR       out  1  one-cycle pulse: out-of-order beat or timeout
//   PAIR_CNT  out  8  completed-pair count (MISC_DEMUX_CNT_EN only)
// -----------------------------------------------------------------------------
module misc_demux_rx #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       VLD,
    input  logic       Y,
    input  logic       S0,
    output logic       A,
    output logic       B,
    output logic       PAIR_VLD,
    output logic       ERR
`ifdef MISC_DEMUX_CNT_EN
    ,
    output logic [7:0] PAIR_CNT
`endif
);

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    // The timeout fires on the idle cycle that would bring the count to
    // TIMEOUT, i.e. when the count already holds TIMEOUT-1 and another idle
    // cycle arrives. A valid beat in that same cycle is not idle, so it is
    // handled by the normal beat rules and suppresses the timeout.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic       a_hold_reg, a_hold_next;
    logic [7:0] tmo_reg, tmo_next;
    logic       a_reg, a_next;
    logic       b_reg, b_next;
    logic       pair_vld_reg, pair_vld_next;
    logic       err_reg, err_next;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= WAIT_A;
            a_hold_reg   <= 1'b0;
            tmo_reg      <= 8'd0;
            a_reg        <= 1'b0;
            b_reg        <= 1'b0;
            pair_vld_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_hold_reg   <= a_hold_next;
            tmo_reg      <= tmo_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            pair_vld_reg <= pair_vld_next;
            err_reg      <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Hold everything by default; the two pulses default low so they can
        // only ever last one cycle.
        state_next    = state_reg;
        a_hold_next   = a_hold_reg;
        tmo_next      = tmo_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        pair_vld_next = 1'b0;
        err_next      = 1'b0;

        unique case (state_reg)
            WAIT_A: begin
                // No partial pair is open, so there is nothing to time out.
                tmo_next = 8'd0;
                if (VLD) begin
                    if (!S0) begin
                        a_hold_next = Y;
                        state_next  = WAIT_B;
                    end else begin
                        // B-phase beat with no A before it: drop it.
                        err_next = 1'b1;
                    end
                end
            end

            WAIT_B: begin
                if (VLD) begin
                    if (S0) begin
                        a_next        = a_hold_reg;
                        b_next        = Y;
                        pair_vld_next = 1'b1;
                        tmo_next      = 8'd0;
                        state_next    = WAIT_A;
                    end else begin
                        // Repeated A-phase beat: flag it, but keep the
                        // newest A and restart the idle window.
                        err_next    = 1'b1;
                        a_hold_next = Y;
                        tmo_next    = 8'd0;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    // Partial pair abandoned; A/B keep their last pair.
                    err_next    = 1'b1;
                    a_hold_next = 1'b0;
                    tmo_next    = 8'd0;
                    state_next  = WAIT_A;
                end else begin
                    tmo_next = tmo_reg + 8'd1;
                end
            end

            default: begin
                state_next = WAIT_A;
                tmo_next   = 8'd0;
            end
        endcase
    end

    assign A        = a_reg;
    assign B        = b_reg;
    assign PAIR_VLD = pair_vld_reg;
    assign ERR      = err_reg;

`ifdef MISC_DEMUX_CNT_EN
    // -------------------------------------------------------------------------
    // Completed-pair counter: follows the registered PAIR_VLD decision so it
    // steps in the same edge the pulse is launched. Wraps freely.
    // -------------------------------------------------------------------------
    logic [7:0] pair_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt_reg <= 8'd0;
        end else if (pair_vld_next) begin
            pair_cnt_reg <= pair_cnt_reg + 8'd1;
        end
    end

    assign PAIR_CNT = pair_cnt_reg;
`endif

endmodule

// File: tb/tb_misc_demux_rx.sv
// -----------------------------------------------------------------------------
// tb_misc_demux_rx
//
// Scoreboard bench for misc_demux_rx. The stimulus process feeds every cycle
// through a reference model that only knows "is an A bit pending, and how
// many idle cycles have passed"; any resulting event (pair, error, reset) is
// queued with the edge number at which the DUT should show it. A monitor on
// the falling edge pops events as their edge arrives and checks PAIR_VLD,
// ERR, A, B (and PAIR_CNT when the counter is built in) every cycle.
// -----------------------------------------------------------------------------
module tb_misc_demux_rx;

    localparam int TIMEOUT = 8;

    localparam int EV_PAIR = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_RST  = 2;

    typedef struct {
        int stamp;
        int kind;
        bit a;
        bit b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic VLD = 1'b0;
    logic Y   = 1'b0;
    logic S0  = 1'b0;
    logic A, B, PAIR_VLD, ERR;
`ifdef MISC_DEMUX_CNT_EN
    logic [7:0] PAIR_CNT;
`endif

    int  tests    = 0;
    int  failures = 0;
    int  edge_cnt = 0;
    int  n_pairs  = 0;
    bit  mon_en   = 1'b0;

    ev_t exp_q[$];

    // Reference model state
    bit  m_pending = 1'b0;
    bit  m_aval    = 1'b0;
    int  m_idle    = 0;

    misc_demux_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .VLD      (VLD),
        .Y        (Y),
        .S0       (S0),
        .A        (A),
        .B        (B),
        .PAIR_VLD (PAIR_VLD),
        .ERR      (ERR)
`ifdef MISC_DEMUX_CNT_EN
        ,
        .PAIR_CNT (PAIR_CNT)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // -------------------------------------------------------------------------
    // Reference model: one call per cycle of stimulus, stamp = sampling edge.
    // -------------------------------------------------------------------------
    function automatic void push_ev(input int stamp, input int kind,
                                    input bit a, input bit b);
        ev_t e;
        e.stamp = stamp;
        e.kind  = kind;
        e.a     = a;
        e.b     = b;
        exp_q.push_back(e);
    endfunction

    function automatic void model(input int stamp, input bit r, input bit v,
                                  input bit s, input bit y);
        if (r) begin
            m_pending = 1'b0;
            m_aval    = 1'b0;
            m_idle    = 0;
            push_ev(stamp, EV_RST, 1'b0, 1'b0);
        end else if (v) begin
            if (!m_pending) begin
                if (!s) begin
                    m_pending = 1'b1;
                    m_aval    = y;
                    m_idle    = 0;
                end else begin
                    push_ev(stamp, EV_ERR, 1'b0, 1'b0);
                end
            end else if (s) begin
                push_ev(stamp, EV_PAIR, m_aval, y);
                m_pending = 1'b0;
                m_idle    = 0;
            end else begin
                push_ev(stamp, EV_ERR, 1'b0, 1'b0);
                m_aval = y;
                m_idle = 0;
            end
        end else if (m_pending) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                push_ev(stamp, EV_ERR, 1'b0, 1'b0);
                m_pending = 1'b0;
                m_idle    = 0;
            end
        end
    endfunction

    // Drive one cycle of inputs (called just after a rising edge or at t=0).
    task automatic cycle(input bit r, input bit v, input bit s, input bit y);
        rst = r;
        VLD = v;
        S0  = s;
        Y   = y;
        model(edge_cnt + 1, r, v, s, y);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    bit   exp_a   = 1'b0;
    bit   exp_b   = 1'b0;
    bit   exp_pv;
    bit   exp_er;
    int   exp_cnt = 0;
    ev_t  cur;
    bit   have;

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].stamp < edge_cnt) begin
                tests++;
                failures++;
                $display("FAIL missed_event edge=%0d kind=%0d stamp=%0d",
                         edge_cnt, exp_q[0].kind, exp_q[0].stamp);
                void'(exp_q.pop_front());
            end
            have = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].stamp == edge_cnt) begin
                cur  = exp_q.pop_front();
                have = 1'b1;
            end
            exp_pv = have && (cur.kind == EV_PAIR);
            exp_er = have && (cur.kind == EV_ERR);
            if (have && cur.kind == EV_RST) begin
                exp_a   = 1'b0;
                exp_b   = 1'b0;
                exp_cnt = 0;
            end
            if (exp_pv) begin
                exp_a   = cur.a;
                exp_b   = cur.b;
                exp_cnt = (exp_cnt + 1) % 256;
                n_pairs++;
            end

            tests++;
            if (PAIR_VLD !== exp_pv || ERR !== exp_er) begin
                failures++;
                $display("FAIL pulses edge=%0d PAIR_VLD=%b ERR=%b expected PAIR_VLD=%b ERR=%b",
                         edge_cnt, PAIR_VLD, ERR, exp_pv, exp_er);
            end
            tests++;
            if (A !== exp_a || B !== exp_b) begin
                failures++;
                $display("FAIL ab_value edge=%0d A=%b B=%b expected A=%b B=%b",
                         edge_cnt, A, B, exp_a, exp_b);
            end
`ifdef MISC_DEMUX_CNT_EN
            tests++;
            if (PAIR_CNT !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL pair_cnt edge=%0d PAIR_CNT=%0d expected %0d",
                         edge_cnt, PAIR_CNT, exp_cnt);
            end
`endif
            if (have) begin
                $display("[TB] edge %0d event kind=%0d A=%b B=%b PAIR_VLD=%b ERR=%b",
                         edge_cnt, cur.kind, A, B, PAIR_VLD, ERR);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int vld_pct;

    initial begin
        mon_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);   // reset overrides a beat

        // Basic pair: A=0, B=1
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // B beat in WAIT_A, then a good pair A=1, B=0
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Timeout after TIMEOUT idles, then a stray B beat
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(TIMEOUT);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);

        // Valid beat on the last idle slot beats the timeout
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(TIMEOUT - 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(TIMEOUT - 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);   // repeated A: error, window restarts
        idle(TIMEOUT - 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Repeated A beat, newest wins
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);

        // Reset drops a partial pair silently
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);

        // 256 full-rate pairs (counter wrap when built in)
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        idle(1);

        // Random traffic with varying beat density
        for (int blk = 0; blk < 16; blk++) begin
            vld_pct = (blk % 3 == 0) ? 95 : ((blk % 3 == 1) ? 15 : 60);
            for (int i = 0; i < 50; i++) begin
                cycle(1'($urandom_range(0, 99) == 0),
                      1'($urandom_range(0, 99) < vld_pct),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
        end

        idle(TIMEOUT + 2);
        @(negedge clk);
        @(negedge clk);

        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain leftover=%0d expected 0", exp_q.size());
        end
        tests++;
        if (n_pairs < 256) begin
            failures++;
            $display("FAIL pair_total seen=%0d expected at least 256", n_pairs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
